// File: rtl/pulse_framer.sv
// rtl/pulse_framer.sv - trigger-based pulse frame assembler between sample FIFO and inference core
module pulse_framer #(
  parameter int WORD_SIZE = 16,
  parameter int FRAME_LEN = 8,
  parameter int PRE_TRIG  = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [WORD_SIZE-1:0]           thresh,
  input  logic                           fifo_empty,
  input  logic [WORD_SIZE-1:0]           fifo_data,
  output logic                           fifo_rd,
  output logic [FRAME_LEN*WORD_SIZE-1:0] frame_data,
  output logic                           frame_valid,
  input  logic                           frame_ready,
  output logic                           busy,
  output logic [15:0]                    frame_count
);

  localparam int HIST_N = (PRE_TRIG > 0) ? PRE_TRIG : 1;
  localparam int FILL_W = (PRE_TRIG > 0) ? $clog2(PRE_TRIG + 1) : 1;
  localparam int IDX_W  = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_HOLD
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [WORD_SIZE-1:0] hist [HIST_N];
  logic [FILL_W-1:0]    hist_fill;
  logic [IDX_W-1:0]     cap_idx;
  logic                 hist_full;
  logic                 hit;
  logic                 trigger;

  assign hist_full   = (hist_fill == FILL_W'(PRE_TRIG));
  assign hit         = (fifo_data >= thresh);
  assign frame_valid = (state == S_HOLD);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fifo_rd    = 1'b0;
    trigger    = 1'b0;
    case (state)
      S_IDLE: begin
        fifo_rd = reset && !fifo_empty && enable;
        if (fifo_rd && hit && hist_full) begin
          trigger    = 1'b1;
          state_next = (PRE_TRIG + 1 == FRAME_LEN) ? S_HOLD : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        fifo_rd = reset && !fifo_empty;
        if (fifo_rd && (cap_idx == IDX_W'(FRAME_LEN - 1))) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (frame_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The trigger compare uses the pre-shift history, so hist[] still holds the words before it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_fill   <= '0;
      cap_idx     <= '0;
      frame_data  <= '0;
      frame_count <= '0;
      for (int k = 0; k < HIST_N; k++) begin
        hist[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo_rd) begin
            if (trigger) begin
              for (int k = 0; k < PRE_TRIG; k++) begin
                frame_data[k*WORD_SIZE +: WORD_SIZE] <= hist[k];
              end
              frame_data[PRE_TRIG*WORD_SIZE +: WORD_SIZE] <= fifo_data;
              cap_idx <= IDX_W'(PRE_TRIG + 1);
            end
            if (!hist_full) begin
              hist_fill <= hist_fill + FILL_W'(1);
            end
            for (int k = 0; k < HIST_N - 1; k++) begin
              hist[k] <= hist[k+1];
            end
            hist[HIST_N-1] <= fifo_data;
          end
        end
        S_CAPTURE: begin
          if (fifo_rd) begin
            for (int k = 0; k < FRAME_LEN; k++) begin
              if (cap_idx == IDX_W'(k)) begin
                frame_data[k*WORD_SIZE +: WORD_SIZE] <= fifo_data;
              end
            end
            cap_idx <= cap_idx + IDX_W'(1);
          end
        end
        S_HOLD: begin
          // Fresh history after every frame so consecutive frames never share samples.
          if (frame_ready) begin
            frame_count <= frame_count + 16'd1;
            hist_fill   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_framer.sv
// tb/tb_pulse_framer.sv - self-checking bench for pulse_framer
module tb_pulse_framer;

  localparam int W  = 16;
  localparam int FL = 8;
  localparam int PT = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            enable = 1'b0;
  logic [W-1:0]    thresh = 16'd100;
  logic            fifo_empty;
  logic [W-1:0]    fifo_data;
  logic            fifo_rd;
  logic [FL*W-1:0] frame_data;
  logic            frame_valid;
  logic            frame_ready = 1'b0;
  logic            busy;
  logic [15:0]     frame_count;

  always #5 clk = ~clk;

  pulse_framer #(.WORD_SIZE(W), .FRAME_LEN(FL), .PRE_TRIG(PT)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .thresh     (thresh),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .busy       (busy),
    .frame_count(frame_count)
  );

  typedef struct {
    int           n;
    logic [W-1:0] in_w [10];
    logic [W-1:0] exp_w [FL];
    int           left;
  } vec_t;

  vec_t            vecs [4];
  logic [W-1:0]    fifo_q [$];
  logic [FL*W-1:0] exp_q [$];
  logic            stall = 1'b0;
  logic            prev_valid = 1'b0;
  logic            rd_seen = 1'b0;
  logic [15:0]     exp_count = 16'd0;
  int              n_checks = 0;
  int              n_fail = 0;

  function automatic logic [FL*W-1:0] pack(input logic [W-1:0] w [FL]);
    logic [FL*W-1:0] r;
    for (int k = 0; k < FL; k++) r[k*W +: W] = w[k];
    return r;
  endfunction

  task automatic check(input string name, input logic [FL*W-1:0] act, input logic [FL*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = stall || (fifo_q.size() == 0);
    fifo_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  // One clock: sample the read strobe, pop the modelled FIFO, then score any new frame.
  task automatic tick();
    logic [FL*W-1:0] e;
    #1;
    rd_seen = fifo_rd;
    @(posedge clk);
    #1;
    if (rd_seen && fifo_q.size() > 0) void'(fifo_q.pop_front());
    drive_fifo();
    #1;
    if (frame_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("frame_data", frame_data, e);
        check("valid_latency", rd_seen, 1);
      end
    end
    prev_valid = frame_valid;
  endtask

  task automatic wait_valid(input int budget);
    int t = 0;
    while (!frame_valid && t < budget) begin
      tick();
      t++;
    end
    check("frame_valid_timeout", frame_valid, 1);
  endtask

  task automatic handshake();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    exp_count = exp_count + 16'd1;
    check("valid_drop", frame_valid, 0);
    check("busy_after_ack", busy, 0);
    check("frame_count", frame_count, exp_count);
  endtask

  task automatic run_vec(input int i);
    logic [FL*W-1:0] snap;
    fifo_q.delete();
    for (int j = 0; j < vecs[i].n; j++) fifo_q.push_back(vecs[i].in_w[j]);
    drive_fifo();
    exp_q.push_back(pack(vecs[i].exp_w));
    wait_valid(40);
    check("left_in_fifo", fifo_q.size(), vecs[i].left);
    snap = frame_data;
    repeat (5) begin
      tick();
      check("hold_stable", frame_data, snap);
      check("hold_no_rd", rd_seen, 0);
      check("hold_busy", busy, 1);
    end
    handshake();
    #1;
    check("idle_read_after_ack", fifo_rd, 1);
    fifo_q.delete();
    drive_fifo();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    vecs[0].n = 9;  vecs[0].left = 1;
    vecs[0].in_w  = '{10, 20, 150, 30, 40, 50, 60, 70, 80, 0};
    vecs[0].exp_w = '{10, 20, 150, 30, 40, 50, 60, 70};
    vecs[1].n = 10; vecs[1].left = 1;
    vecs[1].in_w  = '{200, 5, 6, 100, 1, 2, 3, 4, 5, 9};
    vecs[1].exp_w = '{5, 6, 100, 1, 2, 3, 4, 5};
    vecs[2].n = 10; vecs[2].left = 2;
    vecs[2].in_w  = '{0, 99, 101, 7, 8, 9, 10, 11, 12, 13};
    vecs[2].exp_w = '{0, 99, 101, 7, 8, 9, 10, 11};
    vecs[3].n = 9;  vecs[3].left = 1;
    vecs[3].in_w  = '{255, 255, 255, 1, 2, 3, 4, 5, 6, 0};
    vecs[3].exp_w = '{255, 255, 255, 1, 2, 3, 4, 5};

    // Reset with a non-empty FIFO and enable high
    enable = 1'b1;
    fifo_q = '{16'd1, 16'd2, 16'd3};
    drive_fifo();
    repeat (3) begin
      tick();
      check("reset_fifo_rd", rd_seen, 0);
      check("reset_valid", frame_valid, 0);
      check("reset_count", frame_count, 0);
      check("reset_busy", busy, 0);
    end
    fifo_q.delete();
    drive_fifo();
    reset = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(i);

    // Empty stall after the 4th capture word
    fifo_q = '{16'd10, 16'd20, 16'd150, 16'd1, 16'd2, 16'd3, 16'd4};
    drive_fifo();
    exp_q.push_back({16'd9, 16'd4, 16'd3, 16'd2, 16'd1, 16'd150, 16'd20, 16'd10});
    t = 0;
    while (fifo_q.size() > 0 && t < 20) begin
      tick();
      t++;
    end
    check("stall_prefill", fifo_q.size(), 0);
    fifo_q.push_back(16'd9);
    fifo_q.push_back(16'd99);
    stall = 1'b1;
    drive_fifo();
    repeat (4) begin
      tick();
      check("stall_no_rd", rd_seen, 0);
      check("stall_busy", busy, 1);
      check("stall_no_valid", frame_valid, 0);
    end
    stall = 1'b0;
    drive_fifo();
    wait_valid(10);
    check("stall_left", fifo_q.size(), 1);
    handshake();
    fifo_q.delete();
    drive_fifo();

    // Reset in the middle of CAPTURE, then idle with enable low
    fifo_q = '{16'd1, 16'd2, 16'd150, 16'd3, 16'd4, 16'd5};
    drive_fifo();
    t = 0;
    while (fifo_q.size() > 0 && t < 20) begin
      tick();
      t++;
    end
    check("midcap_busy", busy, 1);
    fifo_q = '{16'd200, 16'd201, 16'd202, 16'd203, 16'd204, 16'd205};
    drive_fifo();
    reset = 1'b0;
    repeat (2) begin
      tick();
      check("midcap_reset_rd", rd_seen, 0);
    end
    reset = 1'b1;
    enable = 1'b0;
    exp_count = 16'd0;
    repeat (5) begin
      tick();
      check("disabled_rd", rd_seen, 0);
      check("disabled_valid", frame_valid, 0);
      check("disabled_busy", busy, 0);
    end
    check("midcap_count_cleared", frame_count, exp_count);
    enable = 1'b1;
    fifo_q.delete();
    drive_fifo();

    // frame_count wrap, preloaded near the top
    @(negedge clk);
    force dut.frame_count = 16'hFFFE;
    #1;
    release dut.frame_count;
    exp_count = 16'hFFFE;
    check("wrap_preload", frame_count, exp_count);
    run_vec(0);
    check("wrap_ffff", frame_count, 16'hFFFF);
    run_vec(0);
    check("wrap_zero", frame_count, 16'h0000);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
